// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the LEGv8 execute-stage ALU: opcodes, FSM states, flag layout.
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_CTL_AND    = 4'b0000;
  localparam logic [3:0] ALU_CTL_ORR    = 4'b0001;
  localparam logic [3:0] ALU_CTL_ADD    = 4'b0010;
  localparam logic [3:0] ALU_CTL_SUB    = 4'b0110;
  localparam logic [3:0] ALU_CTL_PASS_B = 4'b0111;
  localparam logic [3:0] ALU_CTL_NOR    = 4'b1100;
  localparam logic [3:0] ALU_CTL_MUL    = 4'b1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_C = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic v, input logic c);
    logic [3:0] f;
    f        = '0;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    f[FLG_V] = v;
    f[FLG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_unit_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_BPC multiplier bits per cycle.
// done is combinational in the last busy cycle; product is valid alongside it.
module iter_mul #(
  parameter int DATA_W  = 64,
  parameter int MUL_BPC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int MUL_ITERS = DATA_W / MUL_BPC;
  localparam int CNT_W     = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] sum;

  // multiplicand * (low MUL_BPC multiplier bits), truncated to DATA_W
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BPC; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  assign sum     = acc + partial;
  assign done    = busy & (cnt == '0);
  assign product = sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      cnt    <= CNT_W'(MUL_ITERS - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= sum;
      mcand  <= mcand << MUL_BPC;
      mplier <= mplier >> MUL_BPC;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// LEGv8 execute-stage ALU: single-cycle logic/arithmetic ops plus an iterative MUL,
// delivering result and NZVC flags with a one-cycle out_valid pulse.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int MUL_BPC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [3:0]        alu_ctl,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam int MSB = DATA_W - 1;

  alu_state_e        state;
  logic              fire;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W:0]   add_w;
  logic [DATA_W:0]   sub_w;
  logic [DATA_W-1:0] sc_result;
  logic              sc_v;
  logic              sc_c;
  logic              sc_known;

  // Handshake: an operation transfers on any rising edge where in_valid & in_ready;
  // in_valid may be held across busy cycles and is simply ignored until in_ready returns.
  // out_valid is a single-cycle pulse with no back-pressure; result/flags hold afterwards.
  assign in_ready  = (state == ST_IDLE) & ~reset;
  assign fire      = in_valid & in_ready;
  assign mul_start = fire & (alu_ctl == ALU_CTL_MUL);

  always_comb begin
    add_w     = {1'b0, op_a} + {1'b0, op_b};
    sub_w     = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_W + 1)'(1);
    sc_result = '0;
    sc_v      = 1'b0;
    sc_c      = 1'b0;
    sc_known  = 1'b1;
    case (alu_ctl)
      ALU_CTL_AND:    sc_result = op_a & op_b;
      ALU_CTL_ORR:    sc_result = op_a | op_b;
      ALU_CTL_NOR:    sc_result = ~(op_a | op_b);
      ALU_CTL_PASS_B: sc_result = op_b;
      ALU_CTL_ADD: begin
        sc_result = add_w[MSB:0];
        sc_c      = add_w[DATA_W];
        sc_v      = (op_a[MSB] == op_b[MSB]) & (add_w[MSB] != op_a[MSB]);
      end
      ALU_CTL_SUB: begin
        sc_result = sub_w[MSB:0];
        sc_c      = sub_w[DATA_W];
        sc_v      = (op_a[MSB] != op_b[MSB]) & (sub_w[MSB] != op_a[MSB]);
      end
      default:        sc_known = 1'b0;
    endcase
  end

  iter_mul #(
    .DATA_W  (DATA_W),
    .MUL_BPC (MUL_BPC)
  ) u_iter_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            if (alu_ctl == ALU_CTL_MUL) begin
              state <= ST_MUL;
            end else begin
              // unknown opcodes still complete, but report all-zero flags
              out_valid <= 1'b1;
              result    <= sc_result;
              flags     <= sc_known ? pack_flags(sc_result[MSB], sc_result == '0, sc_v, sc_c)
                                    : 4'b0000;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_product;
            flags     <= pack_flags(mul_product[MSB], mul_product == '0, 1'b0, 1'b0);
            state     <= ST_IDLE;
          end else if (!mul_busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
